// File: rtl/aurora_encode_rx_framer.sv
// -----------------------------------------------------------------------------
// aurora_encode_rx_framer
//
// Purpose:
//   Collects the PMT encoder word stream recovered by the Aurora 64b66b RX
//   de-framer (USER_CLK domain). The words are buffered in a first-word-fall-
//   through FIFO and re-emitted as fixed-length packets on a 64-bit
//   valid/ready stream that feeds the PCIe DMA write path. Every packet is one
//   header word followed by PKT_LEN payload words. A short final packet is
//   padded with zero words. Dropped words (FIFO full) are flagged and counted.
//   The end of a frame is reported with a one-cycle done pulse.
//
// Ports:
//   USER_CLK       Aurora user clock; all logic runs on its rising edge
//   RESET          asynchronous, active-high reset
//   rx_start_i     one-cycle pulse, encoder frame begins (accepted in IDLE only)
//   rx_end_i       one-cycle pulse, encoder frame ends (ignored in IDLE)
//   rx_en_i        rx_data_i is valid this cycle
//   rx_data_i      64-bit encoder word
//   m_tvalid_o     output word valid
//   m_tdata_o      output word (header, payload or zero pad)
//   m_tlast_o      last word of the packet
//   m_tready_i     downstream ready
//   busy_o         high from an accepted start until the done pulse
//   frame_done_o   one-cycle pulse once every word of the frame is emitted
//   overflow_o     sticky flag, a word was dropped since the last start
//   drop_cnt_o     dropped-word count, saturates at 16'hFFFF
//
// Handshake: a word moves when m_tvalid_o and m_tready_i are both high on a
// rising edge. While m_tvalid_o is high without m_tready_i, the values of
// m_tvalid_o, m_tdata_o and m_tlast_o do not change. All three are decoded
// from registered state only, and the FIFO head changes only on a pop.
//
// Header word: {HDR_MAGIC, frame_cnt[15:0], n[15:0], pkt_cnt[15:0]}.
// n is the number of real payload words in the packet.
// -----------------------------------------------------------------------------
module aurora_encode_rx_framer #(
   parameter int unsigned PKT_LEN    = 256,
   parameter int unsigned FIFO_DEPTH = 1024,
   parameter logic [15:0] HDR_MAGIC  = 16'hA55A
) (
   input  logic        USER_CLK,
   input  logic        RESET,
   input  logic        rx_start_i,
   input  logic        rx_end_i,
   input  logic        rx_en_i,
   input  logic [63:0] rx_data_i,
   output logic        m_tvalid_o,
   output logic [63:0] m_tdata_o,
   output logic        m_tlast_o,
   input  logic        m_tready_i,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        overflow_o,
   output logic [15:0] drop_cnt_o
);

   localparam int unsigned AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] PKT_CNT_C = (AW+1)'(PKT_LEN);
   localparam logic [15:0] PKT_LEN16 = 16'(PKT_LEN);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_HDR  = 3'd2,
      S_DATA = 3'd3,
      S_PAD  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t         state_q, state_d;

   // FIFO storage and pointers
   logic [63:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;

   // Frame and packet bookkeeping
   logic           end_seen_q, end_seen_d;
   logic           overflow_q, overflow_d;
   logic [15:0]    drop_cnt_q, drop_cnt_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;
   logic [15:0]    pkt_cnt_q, pkt_cnt_d;
   logic [15:0]    n_q, n_d;
   logic [15:0]    word_cnt_q, word_cnt_d;

   // Per-cycle control
   logic           start_acc;
   logic           wr_req;
   logic           wr_ok;
   logic           pop;
   logic           fifo_full;
   logic [AW-1:0]  wr_addr;
   logic           last_data;
   logic           last_pad;

   // ---------------------------------------------------------------------------
   // FIFO write path and occupancy
   // ---------------------------------------------------------------------------
   always_comb begin
      start_acc  = (state_q == S_IDLE) && rx_start_i;
      // A word that arrives with the start pulse is kept; other IDLE words are not.
      wr_req     = rx_en_i && ((state_q != S_IDLE) || rx_start_i);
      pop        = (state_q == S_DATA) && m_tready_i;
      fifo_full  = (count_q == DEPTH_C);
      // The start flush empties the FIFO before the write. A pop in the same
      // cycle frees a slot first, so a full FIFO still takes the word.
      wr_ok      = wr_req && (start_acc || !fifo_full || pop);
      wr_addr    = start_acc ? '0 : wr_ptr_q;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (start_acc) begin
         wr_ptr_d   = wr_ok ? AW'(1) : '0;
         rd_ptr_d   = '0;
         count_d    = wr_ok ? (AW+1)'(1) : '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(wr_ok);
         rd_ptr_d = rd_ptr_q + AW'(pop);
         count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
         if (wr_req && !wr_ok) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge USER_CLK) begin
      if (wr_ok) begin
         mem_q[wr_addr] <= rx_data_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Packet FSM: next state and stream outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      end_seen_d   = end_seen_q;
      frame_cnt_d  = frame_cnt_q;
      pkt_cnt_d    = pkt_cnt_q;
      n_d          = n_q;
      word_cnt_d   = word_cnt_q;
      m_tvalid_o   = 1'b0;
      m_tdata_o    = 64'h0;
      m_tlast_o    = 1'b0;
      frame_done_o = 1'b0;
      last_data    = (word_cnt_q == (n_q - 16'd1));
      last_pad     = (word_cnt_q == (PKT_LEN16 - 16'd1));

      // A word that comes with the end pulse is written before end_seen can be
      // seen, so WAIT never closes a frame ahead of its last word.
      if ((state_q != S_IDLE) && rx_end_i) begin
         end_seen_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_start_i) begin
               state_d     = S_WAIT;
               frame_cnt_d = frame_cnt_q + 16'd1;
               pkt_cnt_d   = '0;
               end_seen_d  = 1'b0;
            end
         end

         S_WAIT: begin
            if (count_q >= PKT_CNT_C) begin
               state_d = S_HDR;
               n_d     = PKT_LEN16;
            end else if (end_seen_q && (count_q != '0)) begin
               state_d = S_HDR;
               n_d     = 16'(count_q);
            end else if (end_seen_q) begin
               state_d = S_DONE;
            end
         end

         S_HDR: begin
            m_tvalid_o = 1'b1;
            m_tdata_o  = {HDR_MAGIC, frame_cnt_q, n_q, pkt_cnt_q};
            if (m_tready_i) begin
               state_d    = S_DATA;
               word_cnt_d = '0;
            end
         end

         S_DATA: begin
            m_tvalid_o = 1'b1;
            m_tdata_o  = mem_q[rd_ptr_q];
            m_tlast_o  = last_data && (n_q == PKT_LEN16);
            if (m_tready_i) begin
               word_cnt_d = word_cnt_q + 16'd1;
               if (last_data) begin
                  if (n_q == PKT_LEN16) begin
                     state_d   = S_WAIT;
                     pkt_cnt_d = pkt_cnt_q + 16'd1;
                  end else begin
                     state_d = S_PAD;
                  end
               end
            end
         end

         S_PAD: begin
            // word_cnt keeps counting payload positions across the pad words.
            m_tvalid_o = 1'b1;
            m_tlast_o  = last_pad;
            if (m_tready_i) begin
               word_cnt_d = word_cnt_q + 16'd1;
               if (last_pad) begin
                  state_d   = S_WAIT;
                  pkt_cnt_d = pkt_cnt_q + 16'd1;
               end
            end
         end

         S_DONE: begin
            frame_done_o = 1'b1;
            end_seen_d   = 1'b0;
            state_d      = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge USER_CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         end_seen_q  <= 1'b0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         frame_cnt_q <= '0;
         pkt_cnt_q   <= '0;
         n_q         <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         end_seen_q  <= end_seen_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
         n_q         <= n_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule
